// File: rtl/spi_master.sv
// Single-byte full-duplex SPI master, MSB first, with selectable SPI mode and SCK divider.
// A transfer takes 16*CLKS_PER_HALF_BIT clocks plus about 2 cycles. Requests are accepted only while o_TX_Ready is high.
module spi_master #(
  parameter int SPI_MODE          = 3,
  parameter int CLKS_PER_HALF_BIT = 4
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_TX_DV,
  output logic       o_TX_Ready,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_SPI_Clk,
  input  logic       i_SPI_MISO,
  output logic       o_SPI_MOSI
);

  localparam int CW = $clog2(2 * CLKS_PER_HALF_BIT);
  localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
  localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_HALF_BIT - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(2 * CLKS_PER_HALF_BIT - 1);

  logic [CW-1:0] half_cnt;
  logic [4:0]    edge_cnt;
  logic          spi_clk;
  logic          lead_edge;
  logic          trail_edge;
  logic          tx_dv_q;
  logic [7:0]    tx_byte_q;
  logic [2:0]    tx_idx;
  logic [2:0]    rx_idx;
  logic [7:1]    rx_shift;
  logic          start;
  logic          tx_shift_en;
  logic          rx_sample_en;

  // A start pulse arriving while busy must not restart or corrupt the transfer.
  assign start        = i_TX_DV & o_TX_Ready;
  assign tx_shift_en  = CPHA ? lead_edge : trail_edge;
  assign rx_sample_en = CPHA ? trail_edge : lead_edge;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_TX_Ready <= 1'b0;
      edge_cnt   <= '0;
      half_cnt   <= '0;
      spi_clk    <= CPOL;
      lead_edge  <= 1'b0;
      trail_edge <= 1'b0;
    end else begin
      lead_edge  <= 1'b0;
      trail_edge <= 1'b0;
      if (start) begin
        o_TX_Ready <= 1'b0;
        edge_cnt   <= 5'd16;
        half_cnt   <= '0;
      end else if (edge_cnt != 5'd0) begin
        o_TX_Ready <= 1'b0;
        if (half_cnt == FULL_LAST) begin
          edge_cnt   <= edge_cnt - 5'd1;
          trail_edge <= 1'b1;
          half_cnt   <= '0;
          spi_clk    <= ~spi_clk;
        end else if (half_cnt == HALF_LAST) begin
          edge_cnt  <= edge_cnt - 5'd1;
          lead_edge <= 1'b1;
          half_cnt  <= half_cnt + 1'b1;
          spi_clk   <= ~spi_clk;
        end else begin
          half_cnt <= half_cnt + 1'b1;
        end
      end else begin
        o_TX_Ready <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      tx_dv_q   <= 1'b0;
      tx_byte_q <= '0;
    end else begin
      tx_dv_q <= start;
      if (start) begin
        tx_byte_q <= i_TX_Byte;
      end
    end
  end

  // One extra register stage keeps SCK aligned with the registered MOSI.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_SPI_Clk <= CPOL;
    end else begin
      o_SPI_Clk <= spi_clk;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_SPI_MOSI <= 1'b0;
      tx_idx     <= 3'd7;
    end else if (o_TX_Ready) begin
      tx_idx <= 3'd7;
    end else if (tx_dv_q && !CPHA) begin
      // Mode 0/2: bit 7 must be on the wire before the first leading edge.
      o_SPI_MOSI <= tx_byte_q[7];
      tx_idx     <= 3'd6;
    end else if (tx_shift_en) begin
      o_SPI_MOSI <= tx_byte_q[tx_idx];
      tx_idx     <= tx_idx - 3'd1;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_RX_DV   <= 1'b0;
      o_RX_Byte <= '0;
      rx_shift  <= '0;
      rx_idx    <= 3'd7;
    end else begin
      o_RX_DV <= 1'b0;
      if (o_TX_Ready) begin
        rx_idx <= 3'd7;
      end else if (rx_sample_en) begin
        if (rx_idx == 3'd0) begin
          o_RX_Byte <= {rx_shift, i_SPI_MISO};
          o_RX_DV   <= 1'b1;
        end else begin
          rx_shift[rx_idx] <= i_SPI_MISO;
        end
        rx_idx <= rx_idx - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Loopback bench for spi_master: five instances covering modes 0-3 at N=4 and mode 0 at N=2.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] tx_dv;
  logic [7:0] tx_byte [5];
  wire  [4:0] tx_ready;
  wire  [4:0] rx_dv;
  wire  [4:0] sck;
  wire  [4:0] mosi;
  wire  [7:0] rx_byte [5];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spi_master #(.SPI_MODE(3), .CLKS_PER_HALF_BIT(4)) u_m3 (
    .i_Clk(clk), .i_Rst(rst), .i_TX_Byte(tx_byte[0]), .i_TX_DV(tx_dv[0]),
    .o_TX_Ready(tx_ready[0]), .o_RX_DV(rx_dv[0]), .o_RX_Byte(rx_byte[0]),
    .o_SPI_Clk(sck[0]), .i_SPI_MISO(mosi[0]), .o_SPI_MOSI(mosi[0]));
  spi_master #(.SPI_MODE(0), .CLKS_PER_HALF_BIT(4)) u_m0 (
    .i_Clk(clk), .i_Rst(rst), .i_TX_Byte(tx_byte[1]), .i_TX_DV(tx_dv[1]),
    .o_TX_Ready(tx_ready[1]), .o_RX_DV(rx_dv[1]), .o_RX_Byte(rx_byte[1]),
    .o_SPI_Clk(sck[1]), .i_SPI_MISO(mosi[1]), .o_SPI_MOSI(mosi[1]));
  spi_master #(.SPI_MODE(1), .CLKS_PER_HALF_BIT(4)) u_m1 (
    .i_Clk(clk), .i_Rst(rst), .i_TX_Byte(tx_byte[2]), .i_TX_DV(tx_dv[2]),
    .o_TX_Ready(tx_ready[2]), .o_RX_DV(rx_dv[2]), .o_RX_Byte(rx_byte[2]),
    .o_SPI_Clk(sck[2]), .i_SPI_MISO(mosi[2]), .o_SPI_MOSI(mosi[2]));
  spi_master #(.SPI_MODE(2), .CLKS_PER_HALF_BIT(4)) u_m2 (
    .i_Clk(clk), .i_Rst(rst), .i_TX_Byte(tx_byte[3]), .i_TX_DV(tx_dv[3]),
    .o_TX_Ready(tx_ready[3]), .o_RX_DV(rx_dv[3]), .o_RX_Byte(rx_byte[3]),
    .o_SPI_Clk(sck[3]), .i_SPI_MISO(mosi[3]), .o_SPI_MOSI(mosi[3]));
  spi_master #(.SPI_MODE(0), .CLKS_PER_HALF_BIT(2)) u_m0_n2 (
    .i_Clk(clk), .i_Rst(rst), .i_TX_Byte(tx_byte[4]), .i_TX_DV(tx_dv[4]),
    .o_TX_Ready(tx_ready[4]), .o_RX_DV(rx_dv[4]), .o_RX_Byte(rx_byte[4]),
    .o_SPI_Clk(sck[4]), .i_SPI_MISO(mosi[4]), .o_SPI_MOSI(mosi[4]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge where o_TX_Ready is seen high again.
  task automatic xfer(input int k, input logic [7:0] b, input int glitch_at,
                      output logic [7:0] rx, output int ndv, output int nedge,
                      output int half, output int cyc);
    logic prev;
    int   t1;
    int   t2;
    ndv = 0; nedge = 0; half = 0; cyc = 0; t1 = -1; t2 = -1;
    tx_byte[k] = b;
    tx_dv[k]   = 1'b1;
    @(negedge clk);
    tx_dv[k] = 1'b0;
    prev = sck[k];
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cyc == glitch_at) begin
        tx_byte[k] = 8'h00;
        tx_dv[k]   = 1'b1;
      end else begin
        tx_dv[k] = 1'b0;
      end
      if (rx_dv[k]) ndv++;
      if (sck[k] !== prev) begin
        nedge++;
        if (t1 < 0) t1 = cyc;
        else if (t2 < 0) t2 = cyc;
        prev = sck[k];
      end
      if (tx_ready[k]) break;
    end
    half = t2 - t1;
    rx   = rx_byte[k];
    check("ready_within_budget", {31'd0, tx_ready[k]}, 32'd1);
  endtask

  task automatic run(input int k, input logic [7:0] b, input int glitch_at,
                     input int n, input logic cpol);
    logic [7:0] rx;
    int ndv, nedge, half, cyc;
    xfer(k, b, glitch_at, rx, ndv, nedge, half, cyc);
    check($sformatf("rx_byte[%0d] %02h", k, b), {24'd0, rx}, {24'd0, b});
    check($sformatf("rx_dv_count[%0d]", k), ndv, 1);
    check($sformatf("sck_edges[%0d]", k), nedge, 16);
    check($sformatf("sck_half_period[%0d]", k), half, n);
    check($sformatf("xfer_len[%0d] cyc=%0d", k, cyc),
          {31'd0, (cyc >= 16 * n) && (cyc <= 16 * n + 3)}, 32'd1);
    check($sformatf("sck_idle[%0d]", k), {31'd0, sck[k]}, {31'd0, cpol});
  endtask

  initial begin
    int dv_seen;
    rst   = 1'b1;
    tx_dv = '0;
    for (int k = 0; k < 5; k++) tx_byte[k] = 8'h00;
    repeat (3) @(negedge clk);

    check("reset_tx_ready", {27'd0, tx_ready}, 32'h00);
    check("reset_rx_dv", {27'd0, rx_dv}, 32'h00);
    check("reset_mosi", {27'd0, mosi}, 32'h00);
    check("reset_sck_cpol", {27'd0, sck}, 32'h09);
    check("reset_rx_byte", {24'd0, rx_byte[0]}, 32'h00);

    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {27'd0, tx_ready}, 32'h1f);

    run(0, 8'hC1, 0, 4, 1'b1);
    run(0, 8'hBE, 0, 4, 1'b1);
    run(0, 8'hEF, 0, 4, 1'b1);

    run(1, 8'hA5, 0, 4, 1'b0);
    run(1, 8'h5A, 0, 4, 1'b0);
    run(2, 8'hA5, 0, 4, 1'b0);
    run(2, 8'h5A, 0, 4, 1'b0);
    run(3, 8'hA5, 0, 4, 1'b1);
    run(3, 8'h5A, 0, 4, 1'b1);

    run(0, 8'hFF, 20, 4, 1'b1);

    tx_byte[0] = 8'h96;
    tx_dv[0]   = 1'b1;
    @(negedge clk);
    tx_dv[0] = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_tx_ready", {31'd0, tx_ready[0]}, 32'd0);
    check("midrst_rx_dv", {31'd0, rx_dv[0]}, 32'd0);
    check("midrst_rx_byte", {24'd0, rx_byte[0]}, 32'h00);
    check("midrst_mosi", {31'd0, mosi[0]}, 32'd0);
    check("midrst_sck", {31'd0, sck[0]}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    dv_seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (rx_dv[0]) dv_seen++;
    end
    check("midrst_no_rx_dv", dv_seen, 0);
    check("midrst_ready_back", {31'd0, tx_ready[0]}, 32'd1);
    run(0, 8'h3C, 0, 4, 1'b1);

    run(4, 8'h81, 0, 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
